// File: rtl/banked_memory_pkg.sv
// Shared types and helpers for the banked_memory RAM: clear-sequencer state
// encoding, lane-count helper and per-lane even-parity function.
package mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

    function automatic int nlanes(input int dwidth, input int lwidth);
        return dwidth / lwidth;
    endfunction

    // Callers zero-extend a lane into the 64-bit argument; zeros do not change parity.
    function automatic logic lane_parity(input logic [63:0] lane);
        return ^lane;
    endfunction

endpackage

// File: rtl/banked_memory_clear_seq.sv
// Post-reset clear sequencer for banked_memory: walks every address once,
// requesting a zero write per cycle, and holds busy until the sweep completes.
module mem_clear_seq
    import mem_pkg::*;
#(
    parameter int AWIDTH = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              busy,
    output logic              clr_we,
    output logic [AWIDTH-1:0] clr_addr
);

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] clr_ptr_q, clr_ptr_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // The pointer wraps naturally, so the last clear leaves it at 0 for the next sweep.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        clr_we    = 1'b0;
        busy      = 1'b1;
        case (state_q)
            CLEAR: begin
                clr_we    = rst_n;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == {AWIDTH{1'b1}}) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                busy = !rst_n;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    assign clr_addr = clr_ptr_q;

endmodule

// File: rtl/banked_memory.sv
// Single-port RAM on a shared tri-state bus with lane write enables, registered
// read + rvalid strobe and post-reset clear. Optional parity: BANKED_MEMORY_PARITY_EN.
module banked_memory
    import mem_pkg::*;
#(
    parameter  int AWIDTH = 5,
    parameter  int DWIDTH = 16,
    parameter  int LWIDTH = 8,
    localparam int NLANES = nlanes(DWIDTH, LWIDTH),
    localparam int DEPTH  = 1 << AWIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic              rd,
    input  logic [NLANES-1:0] be,
    input  logic [AWIDTH-1:0] addr,
    inout  wire  [DWIDTH-1:0] data,
    output logic              busy,
    output logic              rvalid,
    output logic              perr
);

    logic              clr_we;
    logic [AWIDTH-1:0] clr_addr;

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic [DWIDTH-1:0] cur_word;
    logic              user_we;
    logic              rd_en;
    logic              mem_we;
    logic [AWIDTH-1:0] mem_waddr;
    logic [DWIDTH-1:0] mem_wdata;

    mem_clear_seq #(
        .AWIDTH(AWIDTH)
    ) u_clear_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_addr(clr_addr)
    );

    // While rvalid is high the block owns the bus, so a write then is dropped
    // and a concurrent read is still served.
    always_comb begin
        cur_word  = mem_q[addr];
        user_we   = !busy && wr && !rvalid_q && (|be);
        rd_en     = !busy && rd && !(wr && !rvalid_q);
        rvalid_d  = rd_en;
        rdata_d   = rd_en ? cur_word : rdata_q;
        mem_we    = clr_we || user_we;
        mem_waddr = clr_we ? clr_addr : addr;
        mem_wdata = '0;
        if (!clr_we) begin
            for (int i = 0; i < NLANES; i++) begin
                mem_wdata[i*LWIDTH +: LWIDTH] = be[i] ? data[i*LWIDTH +: LWIDTH]
                                                      : cur_word[i*LWIDTH +: LWIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
        if (!rst_n) begin
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rvalid_d;
        end
    end

    assign rvalid = rvalid_q;
    assign data   = rvalid_q ? rdata_q : {DWIDTH{1'bz}};

`ifdef BANKED_MEMORY_PARITY_EN
    logic [NLANES-1:0] par_q [DEPTH];
    logic [NLANES-1:0] cur_par;
    logic [NLANES-1:0] par_wdata;
    logic [NLANES-1:0] par_calc;
    logic              perr_q, perr_d;

    always_comb begin
        cur_par   = par_q[addr];
        par_wdata = '0;
        par_calc  = '0;
        for (int i = 0; i < NLANES; i++) begin
            par_calc[i] = lane_parity(64'(cur_word[i*LWIDTH +: LWIDTH]));
            if (!clr_we) begin
                par_wdata[i] = be[i] ? lane_parity(64'(data[i*LWIDTH +: LWIDTH])) : cur_par[i];
            end
        end
        perr_d = rd_en && (|(par_calc ^ cur_par));
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            par_q[mem_waddr] <= par_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign perr = perr_q;
`else
    assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_banked_memory.sv
// Self-checking bench for banked_memory: directed vector table, reset/clear
// corner sequences and randomized traffic against a word-level reference model.
module tb_banked_memory;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr;
    logic        rd;
    logic [1:0]  be;
    logic [4:0]  addr;
    wire  [15:0] data;
    logic        busy;
    logic        rvalid;
    logic        perr;

    logic [15:0] drv_data;
    logic        drv_en;

    int checks   = 0;
    int failures = 0;

    logic [15:0] model_mem [32];
    logic        model_rv;
    logic [15:0] model_rd;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [1:0]  be;
        logic [4:0]  addr;
        logic [15:0] wdata;
        logic        exp_rv;
        logic [15:0] exp_data;
        logic        chk_bus;
        string       name;
    } vec_t;

    vec_t vecs[$];

    assign data = drv_en ? drv_data : 16'hzzzz;

    always #5 clk = ~clk;

    banked_memory dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (wr),
        .rd    (rd),
        .be    (be),
        .addr  (addr),
        .data  (data),
        .busy  (busy),
        .rvalid(rvalid),
        .perr  (perr)
    );

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drives one request at a negedge and returns at the next negedge, when outputs are settled.
    task automatic applyStimulus(input logic w, input logic r, input logic [1:0] b,
                                 input logic [4:0] a, input logic [15:0] d, input logic drive);
        wr       = w;
        rd       = r;
        be       = b;
        addr     = a;
        drv_data = d;
        drv_en   = drive;
        @(posedge clk);
        @(negedge clk);
        wr     = 1'b0;
        rd     = 1'b0;
        drv_en = 1'b0;
    endtask

    // Word-level behaviour: a write lands only when the bus is free, a read is
    // dropped only by an accepted-priority write, read data is the pre-edge word.
    task automatic modelStep(input logic w, input logic r, input logic [1:0] b,
                             input logic [4:0] a, input logic [15:0] d);
        logic wok;
        logic rok;
        wok      = w && !model_rv && (b != 2'b00);
        rok      = r && !(w && !model_rv);
        model_rd = model_mem[a];
        if (wok) begin
            if (b[0]) model_mem[a][7:0]  = d[7:0];
            if (b[1]) model_mem[a][15:8] = d[15:8];
        end
        model_rv = rok;
    endtask

    task automatic modelReset();
        for (int i = 0; i < 32; i++) model_mem[i] = 16'h0000;
        model_rv = 1'b0;
    endtask

    task automatic runCycle(input logic w, input logic r, input logic [1:0] b,
                            input logic [4:0] a, input logic [15:0] d);
        logic drive;
        drive = w && !model_rv;
        modelStep(w, r, b, a, d);
        applyStimulus(w, r, b, a, d, drive);
    endtask

    // Bench drives zero on the bus; any leftover DUT drive of nonzero rdata shows up.
    task automatic busReleased(input string name);
        drv_data = 16'h0000;
        drv_en   = 1'b1;
        #1;
        checkOutput(name, data, 16'h0000);
        drv_en = 1'b0;
    endtask

    task automatic waitClear(input string name);
        int cnt;
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        checkOutput(name, 16'(cnt), 16'd32);
    endtask

    initial begin
        rst_n    = 1'b0;
        wr       = 1'b0;
        rd       = 1'b0;
        be       = 2'b00;
        addr     = 5'd0;
        drv_data = 16'h0000;
        drv_en   = 1'b0;
        modelReset();

        vecs.push_back('{1'b1, 1'b0, 2'b11, 5'd7,  16'hA5C3, 1'b0, 16'h0000, 1'b0, "w7_full"});
        vecs.push_back('{1'b1, 1'b0, 2'b01, 5'd7,  16'hFFFF, 1'b0, 16'h0000, 1'b0, "w7_lane0"});
        vecs.push_back('{1'b0, 1'b1, 2'b00, 5'd7,  16'h0000, 1'b1, 16'hA5FF, 1'b0, "r7_merge"});
        vecs.push_back('{1'b0, 1'b0, 2'b00, 5'd0,  16'h0000, 1'b0, 16'h0000, 1'b1, "idle_after_r7"});
        vecs.push_back('{1'b1, 1'b0, 2'b11, 5'd1,  16'h0001, 1'b0, 16'h0000, 1'b0, "w1"});
        vecs.push_back('{1'b1, 1'b0, 2'b11, 5'd2,  16'h0002, 1'b0, 16'h0000, 1'b0, "w2"});
        vecs.push_back('{1'b1, 1'b0, 2'b11, 5'd3,  16'h0003, 1'b0, 16'h0000, 1'b0, "w3"});
        vecs.push_back('{1'b1, 1'b0, 2'b11, 5'd4,  16'h0004, 1'b0, 16'h0000, 1'b0, "w4"});
        vecs.push_back('{1'b0, 1'b1, 2'b00, 5'd1,  16'h0000, 1'b1, 16'h0001, 1'b0, "b2b_r1"});
        vecs.push_back('{1'b0, 1'b1, 2'b00, 5'd2,  16'h0000, 1'b1, 16'h0002, 1'b0, "b2b_r2"});
        vecs.push_back('{1'b0, 1'b1, 2'b00, 5'd3,  16'h0000, 1'b1, 16'h0003, 1'b0, "b2b_r3"});
        vecs.push_back('{1'b0, 1'b1, 2'b00, 5'd4,  16'h0000, 1'b1, 16'h0004, 1'b0, "b2b_r4"});
        vecs.push_back('{1'b0, 1'b0, 2'b00, 5'd0,  16'h0000, 1'b0, 16'h0000, 1'b1, "idle_after_b2b"});
        vecs.push_back('{1'b1, 1'b1, 2'b11, 5'd9,  16'h1234, 1'b0, 16'h0000, 1'b1, "wr_rd9_drop"});
        vecs.push_back('{1'b0, 1'b1, 2'b00, 5'd9,  16'h0000, 1'b1, 16'h1234, 1'b0, "r9"});
        vecs.push_back('{1'b1, 1'b1, 2'b11, 5'd9,  16'h5555, 1'b1, 16'h1234, 1'b0, "wr_during_rv"});
        vecs.push_back('{1'b0, 1'b1, 2'b00, 5'd9,  16'h0000, 1'b1, 16'h1234, 1'b0, "r9_unchanged"});
        vecs.push_back('{1'b0, 1'b0, 2'b00, 5'd0,  16'h0000, 1'b0, 16'h0000, 1'b1, "idle_after_r9"});
        vecs.push_back('{1'b1, 1'b0, 2'b00, 5'd7,  16'h0000, 1'b0, 16'h0000, 1'b0, "w7_be0"});
        vecs.push_back('{1'b0, 1'b1, 2'b00, 5'd7,  16'h0000, 1'b1, 16'hA5FF, 1'b0, "r7_be0_kept"});
        vecs.push_back('{1'b0, 1'b0, 2'b00, 5'd0,  16'h0000, 1'b0, 16'h0000, 1'b1, "idle_before_raw"});
        vecs.push_back('{1'b1, 1'b0, 2'b11, 5'd12, 16'hBEEF, 1'b0, 16'h0000, 1'b0, "w12"});
        vecs.push_back('{1'b0, 1'b1, 2'b00, 5'd12, 16'h0000, 1'b1, 16'hBEEF, 1'b0, "raw_r12"});

        // Power-on reset and full clear sweep
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 16'(busy), 16'd1);
        checkOutput("reset_rvalid", 16'(rvalid), 16'd0);
        checkOutput("reset_perr", 16'(perr), 16'd0);
        rst_n = 1'b1;
        waitClear("clear_len_poweron");
        checkOutput("idle_rvalid", 16'(rvalid), 16'd0);
        for (int a = 0; a < 32; a++) begin
            runCycle(1'b0, 1'b1, 2'b00, 5'(a), 16'h0000);
            checkOutput($sformatf("clr_rv_%0d", a), 16'(rvalid), 16'd1);
            checkOutput($sformatf("clr_data_%0d", a), data, 16'h0000);
        end
        runCycle(1'b0, 1'b0, 2'b00, 5'd0, 16'h0000);
        checkOutput("clr_end_rv", 16'(rvalid), 16'd0);

        // Directed vector table
        foreach (vecs[i]) begin
            runCycle(vecs[i].wr, vecs[i].rd, vecs[i].be, vecs[i].addr, vecs[i].wdata);
            checkOutput({vecs[i].name, "_rv"}, 16'(rvalid), 16'(vecs[i].exp_rv));
            if (vecs[i].exp_rv) begin
                checkOutput({vecs[i].name, "_data"}, data, vecs[i].exp_data);
                checkOutput({vecs[i].name, "_perr"}, 16'(perr), 16'd0);
            end
            if (vecs[i].chk_bus) begin
                busReleased({vecs[i].name, "_bus"});
            end
        end

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            logic        w;
            logic        r;
            logic [1:0]  b;
            logic [4:0]  a;
            logic [15:0] d;
            w = ($urandom_range(0, 9) < 4);
            r = ($urandom_range(0, 9) < 5);
            b = 2'($urandom_range(0, 3));
            a = 5'($urandom_range(0, 31));
            d = 16'($urandom);
            runCycle(w, r, b, a, d);
            checkOutput($sformatf("rand_rv_%0d", n), 16'(rvalid), 16'(model_rv));
            if (model_rv) begin
                checkOutput($sformatf("rand_data_%0d", n), data, model_rd);
                checkOutput($sformatf("rand_perr_%0d", n), 16'(perr), 16'd0);
            end
        end

        // Reset landing on an rvalid cycle
        runCycle(1'b0, 1'b0, 2'b00, 5'd0, 16'h0000);
        runCycle(1'b1, 1'b0, 2'b11, 5'd20, 16'hC0DE);
        runCycle(1'b0, 1'b1, 2'b00, 5'd20, 16'h0000);
        checkOutput("pre_rst_rv", 16'(rvalid), 16'd1);
        checkOutput("pre_rst_data", data, 16'hC0DE);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        modelReset();
        checkOutput("rst_rv_drop", 16'(rvalid), 16'd0);
        checkOutput("rst_busy", 16'(busy), 16'd1);
        busReleased("rst_bus");
        rst_n = 1'b1;
        waitClear("clear_len_after_rv_rst");

        // Reset pulse at sweep cycle 10 restarts the clear
        runCycle(1'b1, 1'b0, 2'b11, 5'd5, 16'h1357);
        runCycle(1'b1, 1'b0, 2'b11, 5'd25, 16'h2468);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("mid_sweep_busy", 16'(busy), 16'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        waitClear("clear_len_restart");
        runCycle(1'b0, 1'b1, 2'b00, 5'd5, 16'h0000);
        checkOutput("restart_r5", data, 16'h0000);
        runCycle(1'b0, 1'b1, 2'b00, 5'd25, 16'h0000);
        checkOutput("restart_r25", data, 16'h0000);
        checkOutput("restart_r25_rv", 16'(rvalid), 16'd1);
        runCycle(1'b0, 1'b0, 2'b00, 5'd0, 16'h0000);

`ifdef BANKED_MEMORY_PARITY_EN
        runCycle(1'b1, 1'b0, 2'b11, 5'd3, 16'h3C5A);
        runCycle(1'b1, 1'b0, 2'b11, 5'd4, 16'h1111);
        dut.mem_q[3] = dut.mem_q[3] ^ 16'h0001;
        model_mem[3] = model_mem[3] ^ 16'h0001;
        runCycle(1'b0, 1'b1, 2'b00, 5'd3, 16'h0000);
        checkOutput("par_flip_rv", 16'(rvalid), 16'd1);
        checkOutput("par_flip_perr", 16'(perr), 16'd1);
        runCycle(1'b0, 1'b1, 2'b00, 5'd4, 16'h0000);
        checkOutput("par_clean_rv", 16'(rvalid), 16'd1);
        checkOutput("par_clean_perr", 16'(perr), 16'd0);
        checkOutput("par_clean_data", data, 16'h1111);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
